// File: rtl/muldiv_funct_unit_if.sv
// Issue and CDB signals between the MULDIV reservation station, the
// iterative RV32M multiply/divide unit and the CDB arbiter.
interface muldiv_funct_unit_if #(
    parameter int NUM_PHYS_REG = 64,
    parameter int ROB_DEPTH    = 16
);
    localparam int PHYS_W = $clog2(NUM_PHYS_REG);
    localparam int ROB_W  = $clog2(ROB_DEPTH);

    // An op transfers on a rising edge where issue_valid && ready; a result
    // transfers on a rising edge where cdb_valid && cdb_grant, and the cdb_*
    // payload stays stable until that edge.
    logic              issue_valid;
    logic [2:0]        issue_funct3;
    logic [31:0]       issue_rs1_v;
    logic [31:0]       issue_rs2_v;
    logic [PHYS_W-1:0] issue_pd;
    logic [4:0]        issue_rd;
    logic [ROB_W-1:0]  issue_rob_idx;
    logic              ready;
    logic              cdb_valid;
    logic [31:0]       cdb_data;
    logic [PHYS_W-1:0] cdb_pd;
    logic [4:0]        cdb_rd;
    logic [ROB_W-1:0]  cdb_rob_idx;
    logic              cdb_grant;
    logic              rob_flush;
    logic [1:0]        dbg_state;

    modport master (
        output issue_valid, issue_funct3, issue_rs1_v, issue_rs2_v,
               issue_pd, issue_rd, issue_rob_idx, cdb_grant, rob_flush,
        input  ready, cdb_valid, cdb_data, cdb_pd, cdb_rd, cdb_rob_idx,
               dbg_state
    );

    modport slave (
        input  issue_valid, issue_funct3, issue_rs1_v, issue_rs2_v,
               issue_pd, issue_rd, issue_rob_idx, cdb_grant, rob_flush,
        output ready, cdb_valid, cdb_data, cdb_pd, cdb_rd, cdb_rob_idx,
               dbg_state
    );
endinterface

// File: rtl/muldiv_funct_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN gives data-dependent early termination.
module muldiv_funct_unit #(
    parameter int NUM_PHYS_REG = 64,
    parameter int ROB_DEPTH    = 16
) (
    input logic                clk,
    input logic                rst,
    muldiv_funct_unit_if.slave bus
);
    localparam int PHYS_W = $clog2(NUM_PHYS_REG);
    localparam int ROB_W  = $clog2(ROB_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [PHYS_W-1:0] pd_q, pd_d;
    logic [4:0]        rd_q, rd_d;
    logic [ROB_W-1:0]  rob_q, rob_d;
    logic              neg_q, neg_d;
    logic [63:0]       acc_q, acc_d;
    logic [63:0]       mcand_q, mcand_d;
    logic [31:0]       mplier_q, mplier_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [31:0]       result_q, result_d;

    logic        accept, is_div, sign_a_en, sign_b_en, sa, sb;
    logic [31:0] a_mag, b_mag;
    logic        div_by_zero, div_ovf;
    logic [5:0]  div_skip;

    assign accept      = bus.issue_valid && (state_q == ST_IDLE) && !bus.rob_flush;
    assign is_div      = bus.issue_funct3[2];
    assign sign_a_en   = is_div ? ~bus.issue_funct3[0] : (bus.issue_funct3[1:0] != 2'b11);
    assign sign_b_en   = is_div ? ~bus.issue_funct3[0] : ~bus.issue_funct3[1];
    assign sa          = sign_a_en & bus.issue_rs1_v[31];
    assign sb          = sign_b_en & bus.issue_rs2_v[31];
    assign a_mag       = sa ? (~bus.issue_rs1_v + 32'd1) : bus.issue_rs1_v;
    assign b_mag       = sb ? (~bus.issue_rs2_v + 32'd1) : bus.issue_rs2_v;
    assign div_by_zero = (bus.issue_rs2_v == 32'd0);
    assign div_ovf     = ~bus.issue_funct3[0] && (bus.issue_rs1_v == 32'h8000_0000)
                         && (bus.issue_rs2_v == 32'hFFFF_FFFF);

`ifdef MULDIV_EARLY_OUT_EN
    function automatic logic [5:0] lzc32(input logic [31:0] v);
        lzc32 = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) lzc32 = 6'(31 - i);
        end
        return lzc32;
    endfunction

    // The first k partial dividends (top k bits of A) are provably below the
    // divisor, so those iterations only shift; capped to keep latency >= 2.
    logic [6:0] skip_raw;
    assign skip_raw = {1'b0, lzc32(a_mag)} + 7'd31 - {1'b0, lzc32(b_mag)};
    assign div_skip = (skip_raw > 7'd30) ? 6'd30 : skip_raw[5:0];
`else
    assign div_skip = 6'd0;
`endif

    logic [63:0] mul_sum, prod;
    logic [32:0] rem_shift, rem_diff;
    logic        q_bit;
    logic [63:0] div_next;
    logic [31:0] div_sel, div_res;
    logic        last_iter, mul_finish;

    assign mul_sum   = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    assign prod      = neg_q ? (~mul_sum + 64'd1) : mul_sum;
    // acc_q holds {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    assign rem_shift = {acc_q[63:32], acc_q[31]};
    assign rem_diff  = rem_shift - {1'b0, mcand_q[31:0]};
    assign q_bit     = ~rem_diff[32];
    assign div_next  = {q_bit ? rem_diff[31:0] : rem_shift[31:0], acc_q[30:0], q_bit};
    assign div_sel   = funct3_q[1] ? div_next[63:32] : div_next[31:0];
    assign div_res   = neg_q ? (~div_sel + 32'd1) : div_sel;
    assign last_iter = (cnt_q == 6'd31);

`ifdef MULDIV_EARLY_OUT_EN
    assign mul_finish = last_iter || ((cnt_q != 6'd0) && (mplier_q[31:1] == 31'd0));
`else
    assign mul_finish = last_iter;
`endif

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        pd_d     = pd_q;
        rd_d     = rd_q;
        rob_d    = rob_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    funct3_d = bus.issue_funct3;
                    pd_d     = bus.issue_pd;
                    rd_d     = bus.issue_rd;
                    rob_d    = bus.issue_rob_idx;
                    cnt_d    = 6'd0;
                    if (!is_div) begin
                        state_d  = ST_MUL;
                        acc_d    = 64'd0;
                        mcand_d  = {32'd0, a_mag};
                        mplier_d = b_mag;
                        neg_d    = sa ^ sb;
                    end else if (div_by_zero) begin
                        state_d  = ST_DONE;
                        result_d = bus.issue_funct3[1] ? bus.issue_rs1_v : 32'hFFFF_FFFF;
                    end else if (div_ovf) begin
                        state_d  = ST_DONE;
                        result_d = bus.issue_funct3[1] ? 32'd0 : 32'h8000_0000;
                    end else begin
                        state_d = ST_DIV;
                        acc_d   = {32'd0, a_mag} << div_skip;
                        mcand_d = {32'd0, b_mag};
                        cnt_d   = div_skip;
                        neg_d   = bus.issue_funct3[1] ? sa : (sa ^ sb);
                    end
                end
            end
            ST_MUL: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
                if (mul_finish) begin
                    state_d  = ST_DONE;
                    result_d = (funct3_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
                end
            end
            ST_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 6'd1;
                if (last_iter) begin
                    state_d  = ST_DONE;
                    result_d = div_res;
                end
            end
            ST_DONE: begin
                if (bus.cdb_grant) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.rob_flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            funct3_q <= '0;
            pd_q     <= '0;
            rd_q     <= '0;
            rob_q    <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            pd_q     <= pd_d;
            rd_q     <= rd_d;
            rob_q    <= rob_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    logic done;
    assign done            = (state_q == ST_DONE);
    assign bus.ready       = (state_q == ST_IDLE);
    assign bus.cdb_valid   = done;
    assign bus.cdb_data    = done ? result_q : 32'd0;
    assign bus.cdb_pd      = done ? pd_q : '0;
    assign bus.cdb_rd      = done ? rd_q : 5'd0;
    assign bus.cdb_rob_idx = done ? rob_q : '0;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_muldiv_funct_unit.sv
// Scoreboard bench for muldiv_funct_unit: directed RV32M vectors, latency,
// CDB hold/grant, flush and reset behaviour.
module tb_muldiv_funct_unit;
    localparam int PHYS_W = 6;
    localparam int ROB_W  = 4;
    localparam int EW     = 32 + PHYS_W + 5 + ROB_W;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   grant_delay = 0;

    logic [EW-1:0] exp_q[$];
    int            lat_q[$];
    int            acc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_funct_unit_if #(.NUM_PHYS_REG(64), .ROB_DEPTH(16)) bus ();

    muldiv_funct_unit #(.NUM_PHYS_REG(64), .ROB_DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] pd, input logic [4:0] rd, input logic [3:0] rob,
                         input logic [31:0] exp_d, input int exp_lat, input bit expect_result);
        int n = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL issue_wait: ready never rose within 200 cycles");
        end
        bus.issue_valid   = 1'b1;
        bus.issue_funct3  = f3;
        bus.issue_rs1_v   = a;
        bus.issue_rs2_v   = b;
        bus.issue_pd      = pd;
        bus.issue_rd      = rd;
        bus.issue_rob_idx = rob;
        @(posedge clk);
        #1;
        if (expect_result) begin
            exp_q.push_back({exp_d, pd, rd, rob});
            lat_q.push_back(exp_lat);
            acc_q.push_back(cyc);
        end
        bus.issue_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(bus.ready), 64'd1);
        check({tag, "_cdb_valid"}, 64'(bus.cdb_valid), 64'd0);
        check({tag, "_cdb_data"}, 64'(bus.cdb_data), 64'd0);
        check({tag, "_cdb_tags"}, 64'({bus.cdb_pd, bus.cdb_rd, bus.cdb_rob_idx}), 64'd0);
        check({tag, "_state"}, 64'(bus.dbg_state), 64'd0);
    endtask

    // Monitor: pops on each new result, checks hold stability, drives grant.
    logic          mon_prev_v = 1'b0;
    logic          mon_granted = 1'b0;
    logic [EW-1:0] mon_snap;
    int            mon_held = 0;
    int            mon_delay = 0;

    initial begin
        logic [EW-1:0] cur, e;
        int l, a;
        bus.cdb_grant = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev_v    = 1'b0;
                mon_granted   = 1'b0;
                bus.cdb_grant = 1'b0;
            end else begin
                cur = {bus.cdb_data, bus.cdb_pd, bus.cdb_rd, bus.cdb_rob_idx};
                if (mon_granted) begin
                    check("ready_after_grant", 64'(bus.ready), 64'd1);
                    check("valid_after_grant", 64'(bus.cdb_valid), 64'd0);
                    mon_granted = 1'b0;
                end
                if (bus.cdb_valid) begin
                    if (!mon_prev_v) begin
                        mon_snap  = cur;
                        mon_held  = 0;
                        mon_delay = grant_delay;
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_result: actual=%0h required=none", cur);
                        end else begin
                            e = exp_q.pop_front();
                            l = lat_q.pop_front();
                            a = acc_q.pop_front();
                            check("cdb_result", 64'(cur), 64'(e));
                            check("latency", 64'(cyc - a + 1), 64'(l));
                        end
                    end else begin
                        check("cdb_stable", 64'(cur), 64'(mon_snap));
                        check("ready_low_in_done", 64'(bus.ready), 64'd0);
                    end
                    if (mon_held >= mon_delay) begin
                        bus.cdb_grant = 1'b1;
                        mon_granted   = 1'b1;
                    end else begin
                        bus.cdb_grant = 1'b0;
                    end
                    mon_held++;
                end else begin
                    bus.cdb_grant = 1'b0;
                end
                mon_prev_v = bus.cdb_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int n;
        rst               = 1'b1;
        bus.issue_valid   = 1'b0;
        bus.issue_funct3  = 3'b000;
        bus.issue_rs1_v   = 32'd0;
        bus.issue_rs2_v   = 32'd0;
        bus.issue_pd      = 6'd0;
        bus.issue_rd      = 5'd0;
        bus.issue_rob_idx = 4'd0;
        bus.rob_flush     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Multiply family
        issue(F_MUL,    32'd7,          32'hFFFF_FFFD, 6'd5,  5'd3,  4'd2,  32'hFFFF_FFEB, 33, 1'b1);
        issue(F_MULH,   32'h8000_0000,  32'h8000_0000, 6'd9,  5'd4,  4'd3,  32'h4000_0000, 33, 1'b1);
        issue(F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 6'd17, 5'd5,  4'd4,  32'hFFFF_FFFE, 33, 1'b1);
        issue(F_MULHSU, 32'hFFFF_FFFF,  32'd2,         6'd33, 5'd6,  4'd5,  32'hFFFF_FFFF, 33, 1'b1);

        // Divide special cases resolve at accept
        issue(F_DIV,    32'd7,          32'd0,         6'd40, 5'd7,  4'd6,  32'hFFFF_FFFF, 1,  1'b1);
        issue(F_REM,    32'h8000_0000,  32'hFFFF_FFFF, 6'd41, 5'd8,  4'd7,  32'h0000_0000, 1,  1'b1);
        issue(F_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 6'd42, 5'd9,  4'd8,  32'h8000_0000, 1,  1'b1);
        issue(F_REM,    32'd7,          32'd0,         6'd43, 5'd10, 4'd9,  32'd7,         1,  1'b1);

        // Signed and unsigned iterative divide
        issue(F_DIV,    32'hFFFF_FFF9,  32'd2,         6'd50, 5'd11, 4'd10, 32'hFFFF_FFFD, 33, 1'b1);
        issue(F_REM,    32'hFFFF_FFF9,  32'd2,         6'd51, 5'd12, 4'd11, 32'hFFFF_FFFF, 33, 1'b1);
        issue(F_REMU,   32'd100,        32'd7,         6'd52, 5'd13, 4'd12, 32'd2,         33, 1'b1);

        // Grant held off for 5 cycles, then a back-to-back issue
        grant_delay = 5;
        issue(F_DIVU,   32'hFFFF_FFFF,  32'h10,        6'd60, 5'd14, 4'd13, 32'h0FFF_FFFF, 33, 1'b1);
        issue(F_MUL,    32'h1234_5678,  32'h10,        6'd61, 5'd15, 4'd14, 32'h2345_6780, 33, 1'b1);
        grant_delay = 0;

        // Issue presented while busy must be ignored
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ready_low_busy", 64'(bus.ready), 64'd0);
            bus.issue_valid  = 1'b1;
            bus.issue_funct3 = F_DIV;
            bus.issue_rs1_v  = 32'd9;
            bus.issue_rs2_v  = 32'd0;
            bus.issue_pd     = 6'd63;
        end
        @(negedge clk);
        bus.issue_valid = 1'b0;

        // Flush in cycle 10 of a DIVU
        issue(F_DIVU, 32'd1000, 32'd3, 6'd20, 5'd16, 4'd15, 32'd0, 0, 1'b0);
        a0 = cyc;
        n  = 0;
        while (cyc != a0 + 9 && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.rob_flush = 1'b1;
        @(negedge clk);
        bus.rob_flush = 1'b0;
        check("flush_ready", 64'(bus.ready), 64'd1);
        check("flush_valid", 64'(bus.cdb_valid), 64'd0);
        issue(F_DIVU, 32'd100, 32'd7, 6'd21, 5'd17, 4'd1, 32'd14, 33, 1'b1);

        // Reset in the middle of a multiply
        issue(F_MUL, 32'd11, 32'd13, 6'd22, 5'd18, 4'd2, 32'd0, 0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midop_reset");
        rst = 1'b0;
        issue(F_MUL, 32'd3, 32'd5, 6'd23, 5'd19, 4'd3, 32'd15, 33, 1'b1);

        n = 0;
        while ((exp_q.size() != 0 || bus.ready !== 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (40) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
